// File: rtl/seq_detect_ctrl_pkg.sv
// rtl/seq_detect_ctrl_pkg.sv - shared types and defaults for the sequence detector slice
package seq_detect_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] PATTERN_1010 = 4'b1010;
    localparam int         PAT_LEN_DEF  = 4;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - byte input handshake bundle
interface seq_detect_ctrl_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/seq_match.sv
// rtl/seq_match.sv - non-overlapping serial pattern matcher (history + fill only)
module seq_match
    import seq_detect_ctrl_pkg::*;
#(
    parameter logic [7:0] PATTERN = 8'(PATTERN_1010),
    parameter int         PAT_LEN = PAT_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    output logic match
);

    localparam int         HW   = PAT_LEN - 1;
    localparam logic [3:0] FULL = 4'(HW);

    logic [HW-1:0]      hist;
    logic [3:0]         fill;
    logic [PAT_LEN-1:0] window;

    assign window = {hist, bit_in};
    assign match  = bit_vld && !clr && (fill == FULL) && (window == PATTERN[PAT_LEN-1:0]);

    // A match empties the history so its bits cannot start the next match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clr || match) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_vld) begin
            hist <= window[HW-1:0];
            if (fill != FULL) begin
                fill <= fill + 4'd1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - byte serialiser, match counter and sticky irq/sat controller
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter logic [7:0] PATTERN = 8'(PATTERN_1010),
    parameter int         PAT_LEN = PAT_LEN_DEF,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] threshold,
    seq_detect_ctrl_if.slave in_if,
    output logic             busy,
    output logic             det_pulse,
    output logic [CNT_W-1:0] det_count,
    output logic             sat,
    output logic             irq
);

    state_t     state, state_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       rdy;
    logic       bit_vld;
    logic       match;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // Ready is gated by reset_n so nothing is offered while held in reset.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        rdy         = 1'b0;
        bit_vld     = 1'b0;
        case (state)
            IDLE: begin
                rdy = enable & reset_n;
                if (rdy && in_if.in_valid) begin
                    shift_nxt   = in_if.in_data;
                    bit_cnt_nxt = 3'd7;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                bit_vld     = 1'b1;
                shift_nxt   = {shift_reg[6:0], 1'b0};
                bit_cnt_nxt = bit_cnt - 3'd1;
                if (bit_cnt == 3'd0) begin
                    rdy = enable & reset_n;
                    if (rdy && in_if.in_valid) begin
                        shift_nxt   = in_if.in_data;
                        bit_cnt_nxt = 3'd7;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_if.in_ready = rdy;
    assign busy           = (state == SHIFT);

    seq_match #(
        .PATTERN (PATTERN),
        .PAT_LEN (PAT_LEN)
    ) u_match (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .bit_vld (bit_vld),
        .bit_in  (shift_reg[7]),
        .match   (match)
    );

    assign cnt_inc = (det_count == '1) ? det_count : det_count + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_pulse <= 1'b0;
            det_count <= '0;
            sat       <= 1'b0;
            irq       <= 1'b0;
        end else if (clear) begin
            det_pulse <= 1'b0;
            det_count <= '0;
            sat       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            det_pulse <= match;
            if (match) begin
                det_count <= cnt_inc;
                if (cnt_inc == '1) begin
                    sat <= 1'b1;
                end
                if ((threshold != '0) && (cnt_inc == threshold)) begin
                    irq <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    localparam int PAT_LEN = 4;
    localparam int PATTERN = 'b1010;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic [7:0] threshold;

    logic       busy1, pulse1, sat1, irq1;
    logic [7:0] cnt1;
    logic       busy2, pulse2, sat2, irq2;
    logic [1:0] cnt2;

    seq_detect_ctrl_if if1();
    seq_detect_ctrl_if if2();

    assign if2.in_data  = if1.in_data;
    assign if2.in_valid = if1.in_valid;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .threshold (threshold),
        .in_if     (if1),
        .busy      (busy1),
        .det_pulse (pulse1),
        .det_count (cnt1),
        .sat       (sat1),
        .irq       (irq1)
    );

    seq_detect_ctrl #(.CNT_W(2)) dut_w2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .threshold (threshold[1:0]),
        .in_if     (if2),
        .busy      (busy2),
        .det_pulse (pulse2),
        .det_count (cnt2),
        .sat       (sat2),
        .irq       (irq2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending bit queue and a sliding history queue.
    bit pending[$];
    bit hist[$];
    int mcount[2];
    bit msat[2];
    bit mirq[2];
    bit mpulse;
    int maxv[2] = '{255, 3};

    int bc, pc;
    bit acc_g;

    typedef struct {
        string      name;
        logic [7:0] thr;
        int         n;
        logic [7:0] b [3];
        int         cnt;
        bit         irq;
        int         cnt2;
        bit         sat2;
        bit         irq2;
    } row_t;

    row_t rows[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        hist.delete();
        for (int k = 0; k < 2; k++) begin
            mcount[k] = 0;
            msat[k]   = 0;
            mirq[k]   = 0;
        end
        mpulse = 0;
    endtask

    function automatic bit exp_ready();
        return reset_n && enable && (pending.size() <= 1);
    endfunction

    function automatic int win();
        int w = 0;
        foreach (hist[i]) w = (w << 1) | int'(hist[i]);
        return w;
    endfunction

    task automatic model_step(output bit acc);
        bit b;
        bit have;
        int thr[2];
        acc = 0;
        b   = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc    = if1.in_valid && exp_ready();
        have   = pending.size() > 0;
        mpulse = 0;
        thr[0] = int'(threshold);
        thr[1] = int'(threshold[1:0]);
        if (have) b = pending.pop_front();
        if (clear) begin
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                mcount[k] = 0;
                msat[k]   = 0;
                mirq[k]   = 0;
            end
        end else if (have) begin
            hist.push_back(b);
            if (hist.size() == PAT_LEN && win() == PATTERN) begin
                hist.delete();
                mpulse = 1;
                for (int k = 0; k < 2; k++) begin
                    if (mcount[k] < maxv[k]) mcount[k]++;
                    if (mcount[k] == maxv[k]) msat[k] = 1;
                    if (thr[k] != 0 && mcount[k] == thr[k]) mirq[k] = 1;
                end
            end else if (hist.size() == PAT_LEN) begin
                void'(hist.pop_front());
            end
        end
        if (acc) begin
            for (int i = 7; i >= 0; i--) pending.push_back(if1.in_data[i]);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",     int'(if1.in_ready), int'(exp_ready()));
        chk("busy",         int'(busy1),        int'(pending.size() > 0));
        chk("det_pulse",    int'(pulse1),       int'(mpulse));
        chk("det_count",    int'(cnt1),         mcount[0]);
        chk("sat",          int'(sat1),         int'(msat[0]));
        chk("irq",          int'(irq1),         int'(mirq[0]));
        chk("det_pulse_w2", int'(pulse2),       int'(mpulse));
        chk("det_count_w2", int'(cnt2),         mcount[1]);
        chk("sat_w2",       int'(sat2),         int'(msat[1]));
        chk("irq_w2",       int'(irq2),         int'(mirq[1]));
    endtask

    task automatic tick(output bit acc);
        @(posedge clk);
        model_step(acc);
        @(negedge clk);
        compare_all();
        if (busy1) bc++;
        if (pulse1) pc++;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int guard;
        if1.in_valid = 1'b1;
        if1.in_data  = d;
        guard = 0;
        acc_g = 0;
        while (!acc_g && guard < 20) begin
            tick(acc_g);
            guard++;
        end
        if (!acc_g) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        if1.in_valid = 1'b0;
        while (busy1 && guard < 20) begin
            tick(acc_g);
            guard++;
        end
        if (busy1) chk("drain_timeout", 0, 1);
        tick(acc_g);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(acc_g);
        clear = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{"aa_thr0",     8'd0, 1, '{8'hAA, 8'h00, 8'h00}, 2, 1'b0, 2, 1'b0, 1'b0};
        rows[1] = '{"cross_05_00", 8'd0, 2, '{8'h05, 8'h00, 8'h00}, 1, 1'b0, 1, 1'b0, 1'b0};
        rows[2] = '{"thr3",        8'd3, 3, '{8'hAA, 8'hA0, 8'hAA}, 5, 1'b1, 3, 1'b1, 1'b1};
        rows[3] = '{"sat",         8'd0, 3, '{8'hAA, 8'hAA, 8'hAA}, 6, 1'b0, 3, 1'b1, 1'b0};

        reset_n      = 1'b0;
        enable       = 1'b1;
        clear        = 1'b0;
        threshold    = 8'd0;
        if1.in_valid = 1'b0;
        if1.in_data  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(if1.in_ready), 0);
        compare_all();
        reset_n = 1'b1;
        tick(acc_g);

        for (int r = 0; r < 4; r++) begin
            threshold = rows[r].thr;
            pulse_clear();
            bc = 0;
            pc = 0;
            for (int j = 0; j < rows[r].n; j++) send_byte(rows[r].b[j]);
            drain();
            chk({rows[r].name, "_count"},  int'(cnt1),  rows[r].cnt);
            chk({rows[r].name, "_pulses"}, pc,          rows[r].cnt);
            chk({rows[r].name, "_busy"},   bc,          8 * rows[r].n);
            chk({rows[r].name, "_irq"},    int'(irq1),  int'(rows[r].irq));
            chk({rows[r].name, "_cnt_w2"}, int'(cnt2),  rows[r].cnt2);
            chk({rows[r].name, "_sat_w2"}, int'(sat2),  int'(rows[r].sat2));
            chk({rows[r].name, "_irq_w2"}, int'(irq2),  int'(rows[r].irq2));
            pulse_clear();
            chk({rows[r].name, "_clr_cnt"}, int'(cnt1) + int'(cnt2), 0);
            chk({rows[r].name, "_clr_flags"}, int'(sat1) + int'(sat2) + int'(irq1) + int'(irq2), 0);
        end

        // Clear while the third bit of 0xAA is presented.
        threshold = 8'd0;
        pc = 0;
        send_byte(8'hAA);
        if1.in_valid = 1'b0;
        tick(acc_g);
        tick(acc_g);
        clear = 1'b1;
        tick(acc_g);
        clear = 1'b0;
        drain();
        chk("clear_mid_count",  int'(cnt1), 1);
        chk("clear_mid_pulses", pc, 1);

        // Reset while bit 5 of 0xAA is presented.
        pulse_clear();
        send_byte(8'hAA);
        if1.in_valid = 1'b0;
        repeat (4) tick(acc_g);
        chk("pre_reset_pulse", int'(pulse1), 1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy",      int'(busy1), 0);
        chk("rst_in_ready",  int'(if1.in_ready), 0);
        chk("rst_det_pulse", int'(pulse1), 0);
        chk("rst_det_count", int'(cnt1), 0);
        chk("rst_sat_irq",   int'(sat1) + int'(irq1), 0);
        repeat (2) tick(acc_g);
        reset_n = 1'b1;
        pc = 0;
        send_byte(8'h0A);
        drain();
        chk("post_reset_count",  int'(cnt1), 1);
        chk("post_reset_pulses", pc, 1);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if1.in_valid = ($urandom_range(0, 3) != 0);
            if1.in_data  = 8'($urandom);
            enable       = ($urandom_range(0, 9) != 0);
            clear        = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) threshold = 8'($urandom_range(0, 6));
            tick(acc_g);
        end
        clear        = 1'b0;
        enable       = 1'b1;
        if1.in_valid = 1'b0;
        repeat (10) tick(acc_g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
